// File: rtl/matrix_keypad_scan.sv
// Row-scanned key matrix with per-key debounce, press/release event FIFO and sticky overflow.
// Define KPD_REPEAT_EN to add auto-repeat of the lowest-index held key (REP_DELAY/REP_RATE in frames).
module matrix_keypad_scan #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 60000,
    parameter int DEB_N      = 2,
    parameter int FIFO_DEPTH = 4
`ifdef KPD_REPEAT_EN
    ,
    parameter int REP_DELAY  = 25,
    parameter int REP_RATE   = 5
`endif
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [COLS-1:0]               col,
    output logic [ROWS-1:0]               row,
    output logic [ROWS*COLS-1:0]          key_state,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(ROWS*COLS)-1:0]  evt_code,
    output logic                          evt_press,
    output logic                          evt_repeat,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int KEYS      = ROWS * COLS;
    localparam int CW        = $clog2(KEYS);
    localparam int RW        = $clog2(ROWS);
    localparam int CLW       = $clog2(COLS);
    localparam int CNTW      = $clog2(SCAN_DIV);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int SAMPLE_AT = SCAN_DIV - COLS - 2;
    localparam int EVAL_LO   = SCAN_DIV - COLS - 1;
`ifdef KPD_REPEAT_EN
    localparam int EW        = CW + 2;
    localparam int RPW       = 16;
`else
    localparam int EW        = CW + 1;
`endif

    logic [CNTW-1:0]              cnt_q, cnt_d;
    logic [ROWS-1:0]              row_q, row_d;
    logic [RW-1:0]                ridx_q, ridx_d;
    logic [COLS-1:0]              sync1_q, sync2_q;
    logic [KEYS-1:0][DEB_N-1:0]   hist_q, hist_d;
    logic [KEYS-1:0]              key_q, key_d;
    logic [FIFO_DEPTH-1:0][EW-1:0] mem_q, mem_d;
    logic [AW:0]                  wp_q, wp_d, rp_q, rp_d;
    logic                         ovf_q, ovf_d;

    logic            wrap, sample_en, eval_en;
    logic [CNTW-1:0] eval_off;
    logic [CLW-1:0]  eval_col;
    logic            push, push_press;
    logic [CW-1:0]   push_code;
    logic [EW-1:0]   entry, head;
    logic            empty, full, pop, accept, drop;
`ifdef KPD_REPEAT_EN
    logic [RPW-1:0]  rep_q, rep_d;
    logic            first_q, first_d;
    logic            push_rep, held_any;
    logic [CW-1:0]   held_idx;
`endif

    always_comb begin
        wrap      = (cnt_q == CNTW'(SCAN_DIV - 1));
        sample_en = (cnt_q == CNTW'(SAMPLE_AT));
        eval_en   = (cnt_q >= CNTW'(EVAL_LO)) && (cnt_q <= CNTW'(SCAN_DIV - 2));
        eval_off  = cnt_q - CNTW'(EVAL_LO);
        eval_col  = eval_off[CLW-1:0];

        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        row_d  = row_q;
        ridx_d = ridx_q;
        if (wrap) begin
            row_d  = {row_q[ROWS-2:0], row_q[ROWS-1]};
            ridx_d = (ridx_q == RW'(ROWS - 1)) ? '0 : ridx_q + 1'b1;
        end

        // Only the currently driven row is sampled, then evaluated one column per cycle
        hist_d     = hist_q;
        key_d      = key_q;
        push       = 1'b0;
        push_press = 1'b0;
        push_code  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (ridx_q == RW'(r)) begin
                    if (sample_en)
                        hist_d[r*COLS+c] = DEB_N'({hist_q[r*COLS+c], ~sync2_q[c]});
                    if (eval_en && eval_col == CLW'(c)) begin
                        if ((&hist_q[r*COLS+c]) && !key_q[r*COLS+c]) begin
                            key_d[r*COLS+c] = 1'b1;
                            push            = 1'b1;
                            push_press      = 1'b1;
                            push_code       = CW'(r*COLS+c);
                        end else if (!(|hist_q[r*COLS+c]) && key_q[r*COLS+c]) begin
                            key_d[r*COLS+c] = 1'b0;
                            push            = 1'b1;
                            push_press      = 1'b0;
                            push_code       = CW'(r*COLS+c);
                        end
                    end
                end
            end
        end

`ifdef KPD_REPEAT_EN
        held_any = 1'b0;
        held_idx = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (key_q[i]) begin
                held_any = 1'b1;
                held_idx = CW'(i);
            end
        end
        // Timer counts slot wraps; a key change never coincides with a wrap
        push_rep = 1'b0;
        rep_d    = rep_q;
        first_d  = first_q;
        if (push || !held_any) begin
            rep_d   = '0;
            first_d = 1'b1;
        end else if (wrap) begin
            if (rep_q == RPW'(first_q ? REP_DELAY * ROWS : REP_RATE * ROWS)) begin
                push       = 1'b1;
                push_rep   = 1'b1;
                push_press = 1'b1;
                push_code  = held_idx;
                rep_d      = RPW'(1);
                first_d    = 1'b0;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
        entry = {push_code, push_press, push_rep};
`else
        entry = {push_code, push_press};
`endif

        empty  = (wp_q == rp_q);
        full   = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        pop    = !empty && evt_ready;
        accept = push && (!full || pop);
        drop   = push && full && !pop;
        wp_d   = accept ? wp_q + 1'b1 : wp_q;
        rp_d   = pop ? rp_q + 1'b1 : rp_q;
        mem_d  = mem_q;
        if (accept)
            mem_d[wp_q[AW-1:0]] = entry;
        ovf_d  = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
        head   = mem_q[rp_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            row_q   <= {{(ROWS-1){1'b1}}, 1'b0};
            ridx_q  <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
            hist_q  <= '0;
            key_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            ovf_q   <= 1'b0;
`ifdef KPD_REPEAT_EN
            rep_q   <= '0;
            first_q <= 1'b1;
`endif
        end else begin
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            ridx_q  <= ridx_d;
            sync1_q <= col;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            key_q   <= key_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            ovf_q   <= ovf_d;
`ifdef KPD_REPEAT_EN
            rep_q   <= rep_d;
            first_q <= first_d;
`endif
        end
    end

    // Storage needs no reset: head fields are masked while the queue is empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign row       = row_q;
    assign key_state = key_q;
    assign overflow  = ovf_q;
    assign evt_valid = !empty;
    assign evt_code  = evt_valid ? head[EW-1 -: CW] : '0;
    assign evt_press = evt_valid & head[EW-1-CW];
`ifdef KPD_REPEAT_EN
    assign evt_repeat = evt_valid & head[0];
`else
    assign evt_repeat = 1'b0;
`endif
endmodule
